// File: rtl/hydra_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : hydra_pkg                                                 |
// | Purpose  : Shared sizing constants, FSM state type and a small fit   |
// |            helper for the port_match_arbiter SRAM-matching engine.   |
// | Contents : PORT_NUM, SRAM_NUM, SCAN_WIDTH, FREE_W, index widths,     |
// |            arb_state_t (IDLE/SCAN/DECIDE), sram_fits().              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package hydra_pkg;

  localparam int PORT_NUM   = 16;  // write frontends
  localparam int SRAM_NUM   = 32;  // shared SRAMs, multiple of SCAN_WIDTH
  localparam int SCAN_WIDTH = 4;   // SRAMs compared per scan cycle
  localparam int FREE_W     = 11;  // free-space count width (half-words)
  localparam int DEST_NUM   = 16;  // destination ports tracked per SRAM
  localparam int DEST_W     = 4;   // destination port index width
  localparam int LEN_W      = 9;   // packet length width (half-words)

  localparam int PORT_W    = $clog2(PORT_NUM);
  localparam int SRAM_W    = $clog2(SRAM_NUM);
  localparam int GROUP_NUM = SRAM_NUM / SCAN_WIDTH;
  localparam int GROUP_W   = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DECIDE = 2'd2
  } arb_state_t;

  // A packet fits when the SRAM has at least as many free half-words.
  function automatic logic sram_fits(input logic [FREE_W-1:0] free,
                                     input logic [LEN_W-1:0]  len);
    return free >= {{(FREE_W-LEN_W){1'b0}}, len};
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rr_arbiter                                                |
// | Purpose  : Combinational round-robin pick: first set request bit at  |
// |            or after the pointer, wrapping around.                    |
// | Ports    : req       in  N      request vector                       |
// |            ptr       in  PTR_W  priority start index                 |
// |            grant_idx out PTR_W  index of the granted requester       |
// |            any_grant out 1      at least one request is set          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N     = 16,
  parameter int PTR_W = 4
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any_grant
);

  int cand;

  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      if (!any_grant && req[cand]) begin
        any_grant = 1'b1;
        grant_idx = PTR_W'(cand);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/port_match_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : port_match_arbiter                                        |
// | Purpose  : Shares one SRAM-matching engine among the write frontends.|
// |            Grants a requester round-robin, scans SCAN_WIDTH SRAMs    |
// |            per cycle for the best fit (dest affinity first, then     |
// |            free space, ties to lower index), reserves the winner for |
// |            the port until its wr_done.                               |
// | Ports    : clk, rst (async, active high)                             |
// |            match_req     in  per-port request level                  |
// |            req_dest_port in  4 bits per port                         |
// |            req_length    in  9 bits per port (half-words)            |
// |            sram_free     in  FREE_W bits per SRAM                    |
// |            sram_has_dest in  16 bits per SRAM                        |
// |            sram_busy     in  per-SRAM lock                           |
// |            wr_done       in  per-port release pulse                  |
// |            match_end     out one-hot success pulse                   |
// |            match_fail    out no-fit pulse                            |
// |            match_sram    out chosen SRAM (0 unless match_end)        |
// |            reserved      out SRAMs reserved by some port             |
// | Config   : `define MATCH_STICKY_EN to reuse the last SRAM chosen for |
// |            a destination when it still fits, skipping the scan.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module port_match_arbiter
  import hydra_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PORT_NUM-1:0]          match_req,
  input  logic [PORT_NUM*DEST_W-1:0]   req_dest_port,
  input  logic [PORT_NUM*LEN_W-1:0]    req_length,
  input  logic [SRAM_NUM*FREE_W-1:0]   sram_free,
  input  logic [SRAM_NUM*DEST_NUM-1:0] sram_has_dest,
  input  logic [SRAM_NUM-1:0]          sram_busy,
  input  logic [PORT_NUM-1:0]          wr_done,
  output logic [PORT_NUM-1:0]          match_end,
  output logic                         match_fail,
  output logic [SRAM_W-1:0]            match_sram,
  output logic [SRAM_NUM-1:0]          reserved
);

  arb_state_t                       state_q, state_d;
  logic [PORT_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [PORT_NUM-1:0]              port_valid_q, port_valid_d;
  logic [PORT_NUM-1:0][SRAM_W-1:0]  port_sram_q, port_sram_d;
  logic [PORT_W-1:0]                cur_port_q, cur_port_d;
  logic [DEST_W-1:0]                cur_dest_q, cur_dest_d;
  logic [LEN_W-1:0]                 cur_len_q, cur_len_d;
  logic [GROUP_W-1:0]               scan_idx_q, scan_idx_d;
  logic [SRAM_NUM-1:0]              excl_q, excl_d;
  logic                             best_valid_q, best_valid_d;
  logic [SRAM_W-1:0]                best_idx_q, best_idx_d;
  logic [FREE_W:0]                  best_score_q, best_score_d;
  logic [PORT_NUM-1:0]              match_end_q, match_end_d;
  logic                             match_fail_q, match_fail_d;
  logic [SRAM_W-1:0]                match_sram_q, match_sram_d;
  logic [SRAM_NUM-1:0]              reserved_q, reserved_d;

  logic [PORT_NUM-1:0] eligible;
  logic [PORT_W-1:0]   grant_idx;
  logic                any_grant;
  logic [DEST_W-1:0]   grant_dest;
  logic [LEN_W-1:0]    grant_len;
  logic                sticky_hit;
  logic [SRAM_W-1:0]   sticky_sram;

  logic [SRAM_W-1:0]   cand_idx;
  logic [FREE_W-1:0]   cand_free;
  logic                cand_ok;
  logic [FREE_W:0]     cand_score;
  logic                scan_valid;
  logic [SRAM_W-1:0]   scan_best_idx;
  logic [FREE_W:0]     scan_best_score;

  // match_end masking covers the cycle before the frontend drops its request.
  assign eligible = match_req & ~match_end_q & ~port_valid_q;

  rr_arbiter #(
    .N     (PORT_NUM),
    .PTR_W (PORT_W)
  ) u_rr_arbiter (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign grant_dest = req_dest_port[int'(grant_idx)*DEST_W +: DEST_W];
  assign grant_len  = req_length[int'(grant_idx)*LEN_W +: LEN_W];

`ifdef MATCH_STICKY_EN
  logic [DEST_NUM-1:0][SRAM_W-1:0] last_sram_q, last_sram_d;
  logic [DEST_NUM-1:0]             last_valid_q, last_valid_d;

  always_comb begin
    sticky_sram = last_sram_q[grant_dest];
    sticky_hit  = last_valid_q[grant_dest]
                & ~sram_busy[sticky_sram]
                & ~reserved_q[sticky_sram]
                & sram_fits(sram_free[int'(sticky_sram)*FREE_W +: FREE_W], grant_len);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_sram_q  <= '0;
      last_valid_q <= '0;
    end else begin
      last_sram_q  <= last_sram_d;
      last_valid_q <= last_valid_d;
    end
  end
`else
  assign sticky_hit  = 1'b0;
  assign sticky_sram = '0;
`endif

  // One group of SCAN_WIDTH candidates, folded into the running best in
  // ascending index order; strict > keeps the lower index on a tie.
  // Reservations come from the snapshot taken at grant, so a release
  // during the scan is not seen by it.
  always_comb begin
    scan_valid      = best_valid_q;
    scan_best_idx   = best_idx_q;
    scan_best_score = best_score_q;
    cand_idx        = '0;
    cand_free       = '0;
    cand_ok         = 1'b0;
    cand_score      = '0;
    for (int j = 0; j < SCAN_WIDTH; j++) begin
      cand_idx   = SRAM_W'(int'(scan_idx_q) * SCAN_WIDTH + j);
      cand_free  = sram_free[int'(cand_idx)*FREE_W +: FREE_W];
      cand_ok    = ~sram_busy[cand_idx] & ~excl_q[cand_idx]
                 & sram_fits(cand_free, cur_len_q);
      cand_score = {sram_has_dest[int'(cand_idx)*DEST_NUM + int'(cur_dest_q)], cand_free};
      if (cand_ok && (!scan_valid || (cand_score > scan_best_score))) begin
        scan_valid      = 1'b1;
        scan_best_idx   = cand_idx;
        scan_best_score = cand_score;
      end
    end
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (any_grant) begin
          state_d = sticky_hit ? DECIDE : SCAN;
        end
      end
      SCAN: begin
        if (scan_idx_q == GROUP_W'(GROUP_NUM - 1)) begin
          state_d = DECIDE;
        end
      end
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: datapath and registered outputs
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    // A release on a port without a reservation clears nothing.
    port_valid_d = port_valid_q & ~wr_done;
    port_sram_d  = port_sram_q;
    cur_port_d   = cur_port_q;
    cur_dest_d   = cur_dest_q;
    cur_len_d    = cur_len_q;
    scan_idx_d   = scan_idx_q;
    excl_d       = excl_q;
    best_valid_d = best_valid_q;
    best_idx_d   = best_idx_q;
    best_score_d = best_score_q;
    match_end_d  = '0;
    match_fail_d = 1'b0;
    match_sram_d = '0;
`ifdef MATCH_STICKY_EN
    last_sram_d  = last_sram_q;
    last_valid_d = last_valid_q;
`endif
    case (state_q)
      IDLE: begin
        if (any_grant) begin
          cur_port_d   = grant_idx;
          cur_dest_d   = grant_dest;
          cur_len_d    = grant_len;
          scan_idx_d   = '0;
          excl_d       = reserved_q;
          // A sticky hit preloads the winner and DECIDE follows directly.
          best_valid_d = sticky_hit;
          best_idx_d   = sticky_sram;
          best_score_d = '0;
        end
      end
      SCAN: begin
        best_valid_d = scan_valid;
        best_idx_d   = scan_best_idx;
        best_score_d = scan_best_score;
        scan_idx_d   = scan_idx_q + GROUP_W'(1);
      end
      DECIDE: begin
        if (best_valid_q) begin
          match_end_d[cur_port_q]  = 1'b1;
          match_sram_d             = best_idx_q;
          port_sram_d[cur_port_q]  = best_idx_q;
          port_valid_d[cur_port_q] = 1'b1;
`ifdef MATCH_STICKY_EN
          last_sram_d[cur_dest_q]  = best_idx_q;
          last_valid_d[cur_dest_q] = 1'b1;
`endif
        end else begin
          match_fail_d = 1'b1;
        end
        rr_ptr_d = (cur_port_q == PORT_W'(PORT_NUM - 1)) ? '0 : cur_port_q + PORT_W'(1);
      end
      default: ;
    endcase
  end

  // Reservation map follows the next-state port table so it lands in the
  // same cycle as match_end or one cycle after wr_done.
  always_comb begin
    reserved_d = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      if (port_valid_d[p]) begin
        reserved_d[port_sram_d[p]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      port_valid_q <= '0;
      port_sram_q  <= '0;
      cur_port_q   <= '0;
      cur_dest_q   <= '0;
      cur_len_q    <= '0;
      scan_idx_q   <= '0;
      excl_q       <= '0;
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_score_q <= '0;
      match_end_q  <= '0;
      match_fail_q <= 1'b0;
      match_sram_q <= '0;
      reserved_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      port_valid_q <= port_valid_d;
      port_sram_q  <= port_sram_d;
      cur_port_q   <= cur_port_d;
      cur_dest_q   <= cur_dest_d;
      cur_len_q    <= cur_len_d;
      scan_idx_q   <= scan_idx_d;
      excl_q       <= excl_d;
      best_valid_q <= best_valid_d;
      best_idx_q   <= best_idx_d;
      best_score_q <= best_score_d;
      match_end_q  <= match_end_d;
      match_fail_q <= match_fail_d;
      match_sram_q <= match_sram_d;
      reserved_q   <= reserved_d;
    end
  end

  assign match_end  = match_end_q;
  assign match_fail = match_fail_q;
  assign match_sram = match_sram_q;
  assign reserved   = reserved_q;

endmodule
`default_nettype wire

// File: tb/tb_port_match_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_port_match_arbiter                                     |
// | Purpose  : Scoreboard bench for port_match_arbiter: stimulus pushes  |
// |            predicted outcomes, a monitor pops them on each pulse.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_port_match_arbiter;

  localparam int NP     = 16;
  localparam int NS     = 32;
  localparam int GROUPS = 8;
`ifdef MATCH_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [15:0]   match_req = '0;
  logic [63:0]   req_dest_port = '0;
  logic [143:0]  req_length = '0;
  logic [351:0]  sram_free = '0;
  logic [511:0]  sram_has_dest = '0;
  logic [31:0]   sram_busy = '0;
  logic [15:0]   wr_done = '0;
  logic [15:0]   match_end;
  logic          match_fail;
  logic [4:0]    match_sram;
  logic [31:0]   reserved;

  port_match_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .match_req     (match_req),
    .req_dest_port (req_dest_port),
    .req_length    (req_length),
    .sram_free     (sram_free),
    .sram_has_dest (sram_has_dest),
    .sram_busy     (sram_busy),
    .wr_done       (wr_done),
    .match_end     (match_end),
    .match_fail    (match_fail),
    .match_sram    (match_sram),
    .reserved      (reserved)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SRAM environment and per-port request fields
  int        cfg_free[NS];
  bit [15:0] cfg_hd[NS];
  bit        cfg_busy[NS];
  int        b_dst[NP];
  int        b_len[NP];

  // Reference model: reservations per port, round-robin pointer, sticky table
  int m_rr;
  bit m_hv[NP];
  int m_hs[NP];
  bit m_lv[16];
  int m_ls[16];

  typedef struct {
    int     port;
    int     sram;
    bit     fail;
    longint cyc;
  } exp_t;
  exp_t sb[$];
  int   drv_port[$];

  task automatic model_reset();
    m_rr = 0;
    for (int p = 0; p < NP; p++) begin
      m_hv[p] = 1'b0;
      m_hs[p] = 0;
    end
    for (int d = 0; d < 16; d++) begin
      m_lv[d] = 1'b0;
      m_ls[d] = 0;
    end
  endtask

  function automatic bit m_reserved(input int s);
    for (int p = 0; p < NP; p++) if (m_hv[p] && m_hs[p] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit [31:0] m_res_vec();
    bit [31:0] v = '0;
    for (int s = 0; s < NS; s++) v[s] = m_reserved(s);
    return v;
  endfunction

  function automatic bit m_fits(input int s, input int len);
    return !cfg_busy[s] && !m_reserved(s) && (cfg_free[s] >= len);
  endfunction

  // Highest (affinity, free) among fitting SRAMs; first one found wins ties.
  function automatic int m_pick(input int len, input int dest);
    int best = -1;
    int bs   = 0;
    int sc;
    for (int s = 0; s < NS; s++) begin
      if (m_fits(s, len)) begin
        sc = (cfg_hd[s][dest] ? 4096 : 0) + cfg_free[s];
        if (best < 0 || sc > bs) begin
          best = s;
          bs   = sc;
        end
      end
    end
    return best;
  endfunction

  // Serve every requesting port once in round-robin order from m_rr.
  task automatic predict(input bit [15:0] mask, input longint t0);
    bit [15:0] pend = mask;
    longint    t = t0;
    int        p, d, l, s, lat, k;
    exp_t      e;
    while (pend != 0) begin
      p = -1;
      for (int i = 0; i < NP; i++) begin
        k = (m_rr + i) % NP;
        if (p < 0 && pend[k]) p = k;
      end
      d   = b_dst[p];
      l   = b_len[p];
      lat = 2 + GROUPS;
      if (STICKY && m_lv[d] && m_fits(m_ls[d], l)) begin
        s   = m_ls[d];
        lat = 2;
      end else begin
        s = m_pick(l, d);
      end
      t      = t + lat;
      e.port = p;
      e.cyc  = t;
      if (s >= 0) begin
        e.sram  = s;
        e.fail  = 1'b0;
        m_hv[p] = 1'b1;
        m_hs[p] = s;
        m_lv[d] = 1'b1;
        m_ls[d] = s;
      end else begin
        e.sram = 0;
        e.fail = 1'b1;
      end
      sb.push_back(e);
      drv_port.push_back(p);
      m_rr    = (p + 1) % NP;
      pend[p] = 1'b0;
    end
  endtask

  task automatic apply_cfg();
    for (int s = 0; s < NS; s++) begin
      sram_free[s*11 +: 11]     = 11'(cfg_free[s]);
      sram_has_dest[s*16 +: 16] = cfg_hd[s];
      sram_busy[s]              = cfg_busy[s];
    end
    for (int p = 0; p < NP; p++) begin
      req_dest_port[p*4 +: 4] = 4'(b_dst[p]);
      req_length[p*9 +: 9]    = 9'(b_len[p]);
    end
  endtask

  task automatic cfg_uniform(input int f);
    for (int s = 0; s < NS; s++) begin
      cfg_free[s] = f;
      cfg_hd[s]   = '0;
      cfg_busy[s] = 1'b0;
    end
  endtask

  task automatic run_batch(input bit [15:0] mask);
    int n, served, budget;
    @(negedge clk);
    apply_cfg();
    drv_port.delete();
    match_req = mask;
    predict(mask, cyc);
    n      = $countones(mask);
    served = 0;
    budget = n * (GROUPS + 4) + 20;
    while (served < n && budget > 0) begin
      @(negedge clk);
      budget--;
      if (match_end != '0 || match_fail) begin
        match_req = match_req & ~match_end;
        if (match_fail && drv_port.size() > served) match_req[drv_port[served]] = 1'b0;
        served++;
      end
    end
    if (served < n) begin
      check("batch_timeout", served, n);
      sb.delete();
      match_req = '0;
    end
    @(negedge clk);
    check("reserved_after_batch", reserved, m_res_vec());
  endtask

  task automatic pulse_wr(input bit [15:0] mask);
    @(negedge clk);
    wr_done = mask;
    for (int p = 0; p < NP; p++) if (mask[p]) m_hv[p] = 1'b0;
    @(negedge clk);
    wr_done = '0;
    check("reserved_after_wr_done", reserved, m_res_vec());
  endtask

  // Monitor: every pulse must match the oldest predicted outcome.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (match_end != '0 || match_fail)) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {match_fail, match_end}, 0);
        end else begin
          e = sb.pop_front();
          check("match_fail", match_fail, e.fail);
          check("match_end", match_end, e.fail ? 0 : (longint'(1) << e.port));
          check("match_sram", match_sram, e.fail ? 0 : e.sram);
          check("outcome_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [15:0] mask, rel;
    model_reset();
    cfg_uniform(0);
    for (int p = 0; p < NP; p++) begin
      b_dst[p] = 0;
      b_len[p] = 0;
    end
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_match_end", match_end, 0);
    check("reset_match_fail", match_fail, 0);
    check("reset_match_sram", match_sram, 0);
    check("reset_reserved", reserved, 0);
    rst = 1'b0;

    // Free-space winner
    cfg_uniform(1000);
    cfg_free[7] = 1200;
    b_dst[3] = 5;
    b_len[3] = 64;
    run_batch(16'h0008);
    check("reserved7_bit", reserved[7], 1);
    pulse_wr(16'h0008);

    // Dest affinity beats free space
    cfg_free[12]  = 100;
    cfg_hd[12][5] = 1'b1;
    run_batch(16'h0008);

    // Reset during scan cycle 4 abandons the scan; port 3 still holds an SRAM
    b_dst[6] = 5;
    b_len[6] = 10;
    @(negedge clk);
    apply_cfg();
    match_req = 16'h0040;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midscan_rst_match_end", match_end, 0);
    check("midscan_rst_match_fail", match_fail, 0);
    check("midscan_rst_match_sram", match_sram, 0);
    check("midscan_rst_reserved", reserved, 0);
    match_req = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);

    // Three simultaneous requesters from rr_ptr=0
    b_dst[0] = 1;  b_len[0] = 50;
    b_dst[5] = 2;  b_len[5] = 50;
    b_dst[15] = 3; b_len[15] = 50;
    run_batch(16'h8021);
    pulse_wr(16'h8021);

    // Nothing fits, then one SRAM grows
    cfg_uniform(200);
    b_dst[9] = 0;
    b_len[9] = 300;
    run_batch(16'h0200);
    cfg_free[2] = 400;
    run_batch(16'h0200);
    pulse_wr(16'h0200);

    // Reserved SRAM excluded until released; release on an idle port ignored
    cfg_uniform(500);
    cfg_free[4] = 1500;
    b_dst[1] = 2; b_len[1] = 10;
    b_dst[2] = 2; b_len[2] = 10;
    run_batch(16'h0002);
    run_batch(16'h0004);
    pulse_wr(16'h0002);
    pulse_wr(16'h0080);
    pulse_wr(16'h0004);
    run_batch(16'h0004);
    pulse_wr(16'h0004);

    // All busy fails; zero length fits an empty SRAM
    for (int s = 0; s < NS; s++) cfg_busy[s] = 1'b1;
    b_dst[11] = 7; b_len[11] = 0;
    run_batch(16'h0800);
    cfg_uniform(0);
    run_batch(16'h0800);
    pulse_wr(16'h0800);

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      for (int s = 0; s < NS; s++) begin
        cfg_free[s] = $urandom_range(0, 1500);
        cfg_hd[s]   = ($urandom_range(0, 2) == 0) ? 16'($urandom()) : 16'h0;
        cfg_busy[s] = ($urandom_range(0, 7) == 0);
      end
      mask = '0;
      for (int p = 0; p < NP; p++) begin
        b_dst[p] = $urandom_range(0, 15);
        b_len[p] = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 511);
        if (!m_hv[p] && $urandom_range(0, 3) == 0) mask[p] = 1'b1;
      end
      if (mask != '0) run_batch(mask);
      rel = 16'(1 << $urandom_range(0, 15));
      for (int p = 0; p < NP; p++) if (m_hv[p] && $urandom_range(0, 1) == 1) rel[p] = 1'b1;
      pulse_wr(rel);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/port_match_arbiter.md
Name: port_match_arbiter

Overview:
- Shares one SRAM-matching engine among the PORT_NUM write frontends.
- Each frontend raises match_enable with the dest port and length of its packet. This block grants one requester round-robin and scans SRAM free-space and dest-occupancy state SCAN_WIDTH SRAMs per cycle.
- Picks the best SRAM that fits, reserves it for the port, and returns a one-hot match_end pulse with the chosen SRAM index. The reservation is released on that port's wr_done.

Parameters:
PORT_NUM, 16, number of write frontends
SRAM_NUM, 32, number of shared SRAMs; must be divisible by SCAN_WIDTH
SCAN_WIDTH, 4, SRAMs compared per scan cycle
FREE_W, 11, width of per-SRAM free-space count (half-words)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
match_req  in  PORT_NUM  per-port match_enable (level, held until match_end)
req_dest_port  in  PORT_NUM*4  dest port of each requester, port p at [4p+3:4p]
req_length  in  PORT_NUM*9  packet length in half-words, port p at [9p+8:9p]
sram_free  in  SRAM_NUM*FREE_W  free half-words per SRAM
sram_has_dest  in  SRAM_NUM*16  bit [16s+d]: SRAM s already queues packets for dest d
sram_busy  in  SRAM_NUM  SRAM excluded (externally locked)
wr_done  in  PORT_NUM  one-cycle pulse: port finished writing, release its reservation
match_end  out  PORT_NUM  one-hot one-cycle pulse to the granted port on success
match_fail  out  1  one-cycle pulse: granted request found no fitting SRAM
match_sram  out  5  chosen SRAM index; valid with match_end or the SRAM index on fail is 0
reserved  out  SRAM_NUM  SRAMs currently reserved by some port

Behaviour:
- Reset: FSM to IDLE, rr_ptr=0, port table cleared, all outputs 0. Any in-flight scan is abandoned and no pulse is issued.
- Eligible(p) = match_req[p] & ~match_end[p] & ~port_valid[p].
  - Masking match_end covers the cycle before the frontend drops match_enable.
- IDLE:
  - If any port is eligible, grant the first eligible port at or after rr_ptr (wrapping).
  - Latch port, dest, length; clear best; go to SCAN with scan_idx=0.
- SCAN (SRAM_NUM/SCAN_WIDTH cycles):
  - Each cycle, candidate s is valid if ~sram_busy[s] & ~reserved[s] & (sram_free[s] >= {2'b0,length}).
  - Score = {sram_has_dest[s][dest], sram_free[s]}; the greater score wins.
  - Ties go to the lower index: strict > against the running best, scanning ascending.
  - Inputs are sampled live each scan cycle.
  - After the last group, go to DECIDE.
- DECIDE:
  - If best is valid (registered outputs): match_end[port]=1, match_sram=best, port_sram[port]=best, port_valid[port]=1.
  - Otherwise match_fail=1.
  - Either way rr_ptr=port+1 mod PORT_NUM, then go to IDLE. A failed port re-requests later without starving others.
- Latency: request eligible in IDLE at cycle T gives match_end/match_fail high in cycle T+2+SRAM_NUM/SCAN_WIDTH (T+10 at defaults). Throughput is one match per 2+SRAM_NUM/SCAN_WIDTH cycles.
- reserved = OR over ports of onehot(port_sram[p]) & port_valid[p]. It is registered and updated the cycle after DECIDE or wr_done.
- wr_done[p] clears port_valid[p] the next cycle.
  - wr_done on a port with no reservation is ignored.
  - A release during SCAN is not seen by that scan.
- Simultaneous wr_done on port a and reservation for port b in one cycle: both are applied.
- Length 0 fits any non-busy, non-reserved SRAM.
- All SRAMs busy or reserved gives match_fail.

Optional Feature:
- Macro MATCH_STICKY_EN.
- Defined:
  - Per-dest table last_sram[16] plus valid bit, written on every successful match.
  - In IDLE, if last_sram[dest] is valid and that SRAM is not busy, not reserved and has free >= length, skip SCAN. DECIDE follows directly, so match_end arrives at T+2.
  - Reset clears the table.
- Undefined: always a full scan; no table.

Decomposition:
- hydra_pkg: PORT_NUM, SRAM_NUM, FREE_W, the port-index and SRAM-index widths, and the arb_state_t enum (IDLE, SCAN, DECIDE).
- One sub-module: rr_arbiter. Inputs are a PORT_NUM request vector and a pointer; outputs are grant index and any_grant; purely combinational.

Test Plan:
- Port 3 req dest=5 len=64; all SRAMs free=1000 except SRAM 7 free=1200 -> match_end[3] at T+10, match_sram=7, reserved[7]=1.
- Same as above, plus sram_has_dest[12][5]=1 with free=100 -> match_sram=12 (dest affinity beats free space).
- Ports 0,5,15 request together, rr_ptr=0 -> grants in order 0,5,15, each 10 cycles apart; rr_ptr=0 after the third; no port granted twice.
- len=300, every SRAM free<300 -> match_fail at T+10, no match_end, rr_ptr advances; raising SRAM 2 free to 400 -> port re-granted, match_sram=2.
- Port 1 holds SRAM 4; port 2 scan finds SRAM 4 excluded; wr_done[1] pulse -> reserved[4] clears next cycle; next port-2 retry may pick 4.
- rst asserted in SCAN cycle 4 -> outputs 0 immediately, no match_end after release. With MATCH_STICKY_EN, a repeated dest=5 request gets match_end at T+2 with the same SRAM.
